servo_pwm_multi: RTL and testbench

Multi-channel hobby-servo PWM generator running directly off the 50 kHz servo clock (20 µs per tick). It produces N_CH independent pulse trains sharing one frame counter, from per-channel target widths written over a simple write port. Targets are clamped to a legal range and applied only at frame boundaries, so no runt or stretched pulses occur. It is the parametrised successor of the fixed single-channel, fixed-width servo driver and sits between the control FSM and the servo pins.

---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_ch.sv | 62 ++++++
 rtl/servo_pwm_multi.sv | 76 +++++++
 tb/tb_servo_pwm_multi.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared tick constants and arithmetic helpers for the multi-channel servo PWM block.
// The optional SERVO_SLEW_EN macro is consumed by servo_ch.
package servo_pkg;

  localparam int FRAME_TICKS_DEF  = 1000;
  localparam int MIN_TICKS_DEF    = 25;
  localparam int MAX_TICKS_DEF    = 125;
  localparam int CENTER_TICKS_DEF = 75;

  function automatic int clamp_ticks(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // Limit a signed width change to +/- step.
  function automatic int slew_step(input int delta, input int step);
    if (delta > step) return step;
    if (delta < -step) return -step;
    return delta;
  endfunction

endpackage

// File: rtl/servo_ch.sv
// One servo channel: target/active widths, latched enable and the registered output.
// Optional SERVO_SLEW_EN limits how far the active width moves per frame.
module servo_ch
  import servo_pkg::*;
#(
  parameter int W            = 10,
  parameter int MAX_TICKS    = MAX_TICKS_DEF,
  parameter int CENTER_TICKS = CENTER_TICKS_DEF,
  parameter int SLEW_STEP    = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         wr_hit,
  input  logic [W-1:0] wr_value,
  input  logic         en_in,
  input  logic [W-1:0] cnt_next,
  output logic         servo,
  output logic [W-1:0] active
);

`ifdef SERVO_SLEW_EN
  localparam int STEP_LIMIT = SLEW_STEP;
`else
  // Any legal jump is at most MAX-MIN, so this limit never bites: the target applies directly.
  localparam int STEP_LIMIT = (SLEW_STEP > MAX_TICKS) ? SLEW_STEP : MAX_TICKS;
`endif

  logic [W-1:0]   target;
  logic [W-1:0]   target_eff;
  logic [W-1:0]   slewed;
  logic [W-1:0]   active_next;
  logic           en_q;
  logic           en_next;
  logic signed [W:0] delta;
  logic signed [W:0] step;

  // Write-through: a write on the boundary edge feeds the frame that starts.
  assign target_eff = wr_hit ? wr_value : target;

  assign delta  = $signed({1'b0, target_eff}) - $signed({1'b0, active});
  assign step   = (W+1)'(slew_step(int'(delta), STEP_LIMIT));
  assign slewed = W'($signed({1'b0, active}) + step);

  assign active_next = load ? slewed : active;
  assign en_next     = load ? en_in : en_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      target <= W'(CENTER_TICKS);
      active <= W'(CENTER_TICKS);
      en_q   <= 1'b1;
      servo  <= 1'b0;
    end else begin
      target <= target_eff;
      active <= active_next;
      en_q   <= en_next;
      servo  <= en_next && (cnt_next < active_next);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM top: shared frame counter, frame tick and write decode.
// Define SERVO_SLEW_EN to rate-limit width changes to SLEW_STEP ticks per frame.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int W            = 10,
  parameter int FRAME_TICKS  = FRAME_TICKS_DEF,
  parameter int MIN_TICKS    = MIN_TICKS_DEF,
  parameter int MAX_TICKS    = MAX_TICKS_DEF,
  parameter int CENTER_TICKS = CENTER_TICKS_DEF,
  parameter int SLEW_STEP    = 2,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [W-1:0]      wr_pulse,
  input  logic [N_CH-1:0]   en_mask,
  output logic [N_CH-1:0]   servo,
  output logic              frame_tick,
  output logic [N_CH*W-1:0] active_dbg
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic [W-1:0] wr_value;
  logic         started;
  logic         load;

  // The first edge after reset opens frame 0 with cnt held at 0, so the
  // opening cycle already shows frame_tick and the rising pulses.
  assign load     = !started || (cnt == W'(FRAME_TICKS - 1));
  assign cnt_next = load ? '0 : cnt + 1'b1;
  assign wr_value = W'(clamp_ticks(int'(wr_pulse), MIN_TICKS, MAX_TICKS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      started    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      started    <= 1'b1;
      frame_tick <= (cnt_next == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic wr_hit;

      // Out-of-range channel indices never match, so those writes drop.
      assign wr_hit = wr_en && (wr_ch == CH_W'(gi));

      servo_ch #(
        .W            (W),
        .MAX_TICKS    (MAX_TICKS),
        .CENTER_TICKS (CENTER_TICKS),
        .SLEW_STEP    (SLEW_STEP)
      ) u_ch (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .wr_hit   (wr_hit),
        .wr_value (wr_value),
        .en_in    (en_mask[gi]),
        .cnt_next (cnt_next),
        .servo    (servo[gi]),
        .active   (active_dbg[gi*W +: W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: stimulus pushes per-frame expectations,
// a monitor measures every completed frame and compares.
module tb_servo_pwm_multi;

  localparam int N_CH   = 3;
  localparam int W      = 10;
  localparam int FRAME  = 1000;
  localparam int MINT   = 25;
  localparam int MAXT   = 125;
  localparam int CENTER = 75;
  localparam int STEP   = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [W-1:0]      wr_pulse = '0;
  logic [N_CH-1:0]   en_mask = '1;
  logic [N_CH-1:0]   servo;
  logic              frame_tick;
  logic [N_CH*W-1:0] active_dbg;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .N_CH         (N_CH),
    .W            (W),
    .FRAME_TICKS  (FRAME),
    .MIN_TICKS    (MINT),
    .MAX_TICKS    (MAXT),
    .CENTER_TICKS (CENTER),
    .SLEW_STEP    (STEP)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_pulse   (wr_pulse),
    .en_mask    (en_mask),
    .servo      (servo),
    .frame_tick (frame_tick),
    .active_dbg (active_dbg)
  );

  typedef struct packed {
    logic [N_CH-1:0][W-1:0] w;
    logic [N_CH-1:0][W-1:0] act;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   tgt[N_CH];
  int   act_m[N_CH];
  int   pos = 5000;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Position inside the frame, referenced to frame_tick.
  always @(negedge clk) begin
    if (!resetn) pos = 5000;
    else if (frame_tick) pos = 0;
    else pos++;
  end

  // ---------------- monitor ----------------
  int                mlen;
  int                mw[N_CH];
  bit                low_seen[N_CH];
  bit                bad[N_CH];
  bit                in_frame = 1'b0;
  int                fno = 0;
  logic [N_CH*W-1:0] dbg_start;

  task automatic finalize();
    exp_t e;
    check($sformatf("f%0d_sb_depth", fno), sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("f%0d_period", fno), mlen, FRAME);
      for (int i = 0; i < N_CH; i++) begin
        check($sformatf("f%0d_ch%0d_width", fno, i), mw[i], int'(e.w[i]));
        check($sformatf("f%0d_ch%0d_contiguous", fno, i), int'(bad[i]), 0);
        check($sformatf("f%0d_ch%0d_active_dbg", fno, i),
              int'(dbg_start[i*W +: W]), int'(e.act[i]));
      end
    end
    fno++;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      in_frame = 1'b0;
    end else begin
      if (frame_tick) begin
        if (in_frame) finalize();
        in_frame  = 1'b1;
        mlen      = 0;
        dbg_start = active_dbg;
        for (int i = 0; i < N_CH; i++) begin
          mw[i] = 0;
          low_seen[i] = 1'b0;
          bad[i] = 1'b0;
        end
      end
      if (in_frame) begin
        mlen++;
        for (int i = 0; i < N_CH; i++) begin
          if (servo[i]) begin
            if (low_seen[i]) bad[i] = 1'b1;
            mw[i]++;
          end else begin
            low_seen[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int clampm(input int v);
    if (v < MINT) return MINT;
    if (v > MAXT) return MAXT;
    return v;
  endfunction

  task automatic goto(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (pos != c && n < 3000);
    if (pos != c) check("goto_timeout", pos, c);
  endtask

  // Enter a new frame and push what it must look like.
  task automatic start_frame();
    exp_t e;
    int   d;
    goto(0);
    for (int i = 0; i < N_CH; i++) begin
      d = tgt[i] - act_m[i];
`ifdef SERVO_SLEW_EN
      if (d > STEP) d = STEP;
      if (d < -STEP) d = -STEP;
`endif
      act_m[i] = act_m[i] + d;
      e.act[i] = W'(act_m[i]);
      e.w[i]   = en_mask[i] ? W'(act_m[i]) : '0;
    end
    sb.push_back(e);
  endtask

  task automatic wr(input int ch, input int val);
    wr_en    = 1'b1;
    wr_ch    = 2'(ch);
    wr_pulse = W'(val);
    if (ch < N_CH) tgt[ch] = clampm(val);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      tgt[i]   = CENTER;
      act_m[i] = CENTER;
    end
  endtask

  logic [N_CH*W-1:0] cen_vec;
  logic [N_CH*W-1:0] clamp_vec;

  initial begin
    cen_vec   = {N_CH{W'(CENTER)}};
    clamp_vec = {10'd125, 10'd100, 10'd25};
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_servo", int'(servo), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    check("rst_active_dbg", int'(active_dbg), int'(cen_vec));
    resetn = 1'b1;

    start_frame();                                   // F0
    check("first_cycle_servo", int'(servo), 7);
    check("first_cycle_tick", int'(frame_tick), 1);
    start_frame();                                   // F1
    goto(500); wr(1, 100);
    start_frame();                                   // F2
    goto(100); wr(0, 10);
    goto(200); wr(2, 300);
    goto(300); wr(3, 60);
    start_frame();                                   // F3
`ifndef SERVO_SLEW_EN
    check("clamp_active_dbg", int'(active_dbg), int'(clamp_vec));
`endif
    goto(999); wr(0, 50);
    start_frame();                                   // F4
    goto(300); en_mask[2] = 1'b0;
    start_frame();                                   // F5
    goto(10); en_mask[2] = 1'b1;
    start_frame();                                   // F6

    goto(0);                                         // F7, cut short by reset
    goto(20);
    resetn = 1'b0;
    #1;
    check("midrst_servo", int'(servo), 0);
    check("midrst_frame_tick", int'(frame_tick), 0);
    check("midrst_active_dbg", int'(active_dbg), int'(cen_vec));
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;

    start_frame();                                   // R0
    check("post_rst_first_servo", int'(servo), 7);
    start_frame();                                   // R1
    goto(0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
